// File: rtl/max_pool_pkg.sv
// Shared types, default geometry and helpers for the max-pooling window sink.
package max_pool_pkg;

    localparam int PIX_WIDTH      = 8;
    localparam int DEF_KERNEL_DIM = 3;
    localparam int DEF_ROW_SIZE   = 5;
    localparam int DEF_COL_SIZE   = 5;
    localparam int DEF_STRIDE     = 2;

    typedef logic [PIX_WIDTH-1:0] pixel_t;

    // Number of pooled outputs along one dimension.
    function automatic int out_dim(input int size, input int k, input int stride);
        return (size - k) / stride + 1;
    endfunction

    localparam int OUT_COLS      = out_dim(DEF_ROW_SIZE, DEF_KERNEL_DIM, DEF_STRIDE);
    localparam int OUT_ROWS      = out_dim(DEF_COL_SIZE, DEF_KERNEL_DIM, DEF_STRIDE);
    localparam int OUT_PER_FRAME = OUT_COLS * OUT_ROWS;

    function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous FIFO holding pooled results; registered head, no bypass, DEPTH a power of 2.
module pool_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || i_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers define what is valid and o_head masks empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/max_pool_window_sink.sv
// Max-pool window sink: keeps stride-grid windows, reduces each to its max, queues results.
// Define MAX_POOL_FRAME_DONE_EN to add the frame_done pulse output.
module max_pool_window_sink
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_WIDTH,
    parameter int KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int ROW_SIZE   = DEF_ROW_SIZE,
    parameter int COL_SIZE   = DEF_COL_SIZE,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] window [KERNEL_DIM][KERNEL_DIM],
    input  logic                  win_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
`ifdef MAX_POOL_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam int K1    = KERNEL_DIM - 1;
    localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [PH_W-1:0]  r_row_ph, r_col_ph, w_row_ph_nxt, w_col_ph_nxt;
    logic             w_row_step;
    logic             w_accept;
    pixel_t           w_row_max   [KERNEL_DIM];
    pixel_t           r_s1_rowmax [KERNEL_DIM];
    logic             r_s1_valid;
    pixel_t           w_win_max;
    logic             w_full;
    logic             w_empty;
    logic             r_overflow;

    // NOTE: each comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_row_step   = (r_col == COL_W'(ROW_SIZE - 1));
        w_col_nxt    = w_row_step ? '0 : r_col + 1'b1;
        w_row_nxt    = r_row;
        w_col_ph_nxt = r_col_ph;
        w_row_ph_nxt = r_row_ph;
        if (w_row_step) w_row_nxt = (r_row == ROW_W'(COL_SIZE - 1)) ? '0 : r_row + 1'b1;
        if (w_col_nxt == COL_W'(K1)) w_col_ph_nxt = '0;
        else if (w_col_nxt > COL_W'(K1))
            w_col_ph_nxt = (r_col_ph == PH_W'(STRIDE - 1)) ? '0 : r_col_ph + 1'b1;
        if (w_row_step) begin
            if (w_row_nxt == ROW_W'(K1)) w_row_ph_nxt = '0;
            else if (w_row_nxt > ROW_W'(K1))
                w_row_ph_nxt = (r_row_ph == PH_W'(STRIDE - 1)) ? '0 : r_row_ph + 1'b1;
        end
    end

    // Counters name the bottom-right pixel of the window currently on the input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row    <= ROW_W'(K1);
            r_col    <= COL_W'(K1);
            r_row_ph <= '0;
            r_col_ph <= '0;
        end else if (win_valid) begin
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_row_ph <= w_row_ph_nxt;
            r_col_ph <= w_col_ph_nxt;
        end
    end

    assign w_accept = win_valid && (r_row >= ROW_W'(K1)) && (r_col >= COL_W'(K1))
                      && (r_row_ph == '0) && (r_col_ph == '0);

    always_comb begin
        for (int r = 0; r < KERNEL_DIM; r++) begin
            w_row_max[r] = window[r][0];
            for (int c = 1; c < KERNEL_DIM; c++) w_row_max[r] = pix_max(w_row_max[r], window[r][c]);
        end
        w_win_max = r_s1_rowmax[0];
        for (int r = 1; r < KERNEL_DIM; r++) w_win_max = pix_max(w_win_max, r_s1_rowmax[r]);
    end

    always_ff @(posedge clk) begin
        if (!rst) r_s1_valid <= 1'b0;
        else      r_s1_valid <= w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_s1_rowmax <= w_row_max;
    end

    // The FIFO entry itself is the second pipeline register, giving a fixed latency of two.
    pool_out_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_s1_valid),
        .i_push_data (w_win_max),
        .i_pop       (out_ready),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst)                                       r_overflow <= 1'b0;
        else if (r_s1_valid && w_full && !out_ready)    r_overflow <= 1'b1;
    end

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

`ifdef MAX_POOL_FRAME_DONE_EN
    localparam int LAST_ROW = K1 + (out_dim(COL_SIZE, KERNEL_DIM, STRIDE) - 1) * STRIDE;
    localparam int LAST_COL = K1 + (out_dim(ROW_SIZE, KERNEL_DIM, STRIDE) - 1) * STRIDE;

    logic r_s1_last;
    logic r_frame_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_last    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_last    <= w_accept && (r_row == ROW_W'(LAST_ROW)) && (r_col == COL_W'(LAST_COL));
            r_frame_done <= r_s1_last;
        end
    end

    assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_max_pool_window_sink.sv
// Self-checking bench for max_pool_window_sink: stride-2 and stride-1 instances against an image-level model.
module tb_max_pool_window_sink;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int RS   = 5;
    localparam int CS   = 5;
    localparam int NPOS = RS * CS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          win_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] window [K][K];
    logic [DW-1:0] out_data, out_data1;
    logic          out_valid, out_valid1, overflow, overflow1;
`ifdef MAX_POOL_FRAME_DONE_EN
    logic          frame_done, frame_done1;
    int            fd_cnt2, fd_cnt1, fd_data1;
    bit            fd_valid1;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dut_pos;
    int img [CS][RS];
    int ready_at_pos = -1;
    bit ready_rand = 1'b0;
    int exp2[$], exp2_cyc[$], exp1[$];
    int got2[$], got2_cyc[$], got1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_pool_window_sink #(.DATA_WIDTH(DW), .KERNEL_DIM(K), .ROW_SIZE(RS), .COL_SIZE(CS),
                           .STRIDE(2), .FIFO_DEPTH(4)) dut (
        .clk (clk), .rst (rst), .window (window), .win_valid (win_valid),
        .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready), .overflow (overflow)
`ifdef MAX_POOL_FRAME_DONE_EN
        , .frame_done (frame_done)
`endif
    );

    max_pool_window_sink #(.DATA_WIDTH(DW), .KERNEL_DIM(K), .ROW_SIZE(RS), .COL_SIZE(CS),
                           .STRIDE(1), .FIFO_DEPTH(4)) dut1 (
        .clk (clk), .rst (rst), .window (window), .win_valid (win_valid),
        .out_data (out_data1), .out_valid (out_valid1), .out_ready (out_ready), .overflow (overflow1)
`ifdef MAX_POOL_FRAME_DONE_EN
        , .frame_done (frame_done1)
`endif
    );

    // Record every accepted output (and frame_done) away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got2.push_back(int'(out_data));
            got2_cyc.push_back(cyc);
        end
        if (out_valid1 && out_ready) got1.push_back(int'(out_data1));
`ifdef MAX_POOL_FRAME_DONE_EN
        if (frame_done) fd_cnt2++;
        if (frame_done1) begin
            fd_cnt1++;
            fd_data1  = int'(out_data1);
            fd_valid1 = out_valid1;
        end
`endif
    end

    function automatic bit kept(input int r, input int c, input int s);
        return (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % s == 0) && ((c - (K - 1)) % s == 0);
    endfunction

    function automatic int win_max(input int r, input int c);
        int m = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                if (img[r - K + 1 + i][c - K + 1 + j] > m) m = img[r - K + 1 + i][c - K + 1 + j];
        return m;
    endfunction

    task automatic clear_q();
        exp2.delete(); exp2_cyc.delete(); exp1.delete();
        got2.delete(); got2_cyc.delete(); got1.delete();
`ifdef MAX_POOL_FRAME_DONE_EN
        fd_cnt2 = 0; fd_cnt1 = 0; fd_data1 = 0; fd_valid1 = 1'b0;
`endif
    endtask

    task automatic step_ready(input int pos);
        if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
        if (pos == ready_at_pos) out_ready = 1'b1;
    endtask

    task automatic idle();
        step_ready(-2);
        win_valid = 1'b0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) window[i][j] = DW'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic present(input int pos);
        int r = pos / RS;
        int c = pos % RS;
        step_ready(pos);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
                int rr = r - (K - 1) + i;
                int cc = c - (K - 1) + j;
                window[i][j] = (rr >= 0 && cc >= 0) ? DW'(img[rr][cc]) : DW'($urandom);
            end
        win_valid = 1'b1;
        if (kept(r, c, 2)) begin
            exp2.push_back(win_max(r, c));
            exp2_cyc.push_back(cyc + 2);
        end
        if (kept(r, c, 1)) exp1.push_back(win_max(r, c));
        @(posedge clk); #1;
    endtask

    task automatic stream_frame(input bit gaps);
        do begin
            if (gaps) begin
                int n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) idle();
            end
            present(dut_pos);
            dut_pos = (dut_pos + 1) % NPOS;
        end while (dut_pos != 0);
        win_valid = 1'b0;
    endtask

    task automatic set_ramp(input bit down);
        for (int r = 0; r < CS; r++)
            for (int c = 0; c < RS; c++) img[r][c] = down ? (NPOS - 1 - (r * RS + c)) : (r * RS + c);
    endtask

    task automatic set_random();
        for (int r = 0; r < CS; r++)
            for (int c = 0; c < RS; c++) img[r][c] = $urandom_range(0, 255);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        win_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        dut_pos = (K - 1) * RS + (K - 1);
        clear_q();
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        win_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1: got %b expected 0", out_valid1); end
`ifdef MAX_POOL_FRAME_DONE_EN
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
`endif
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
        dut_pos = (K - 1) * RS + (K - 1);
        clear_q();
    endtask

    task automatic test_ramp(input bit down);
        clear_q();
        set_ramp(down);
        out_ready = 1'b1;
        stream_frame(down);
        repeat (6) idle();
        checks++; if (got2.size() != exp2.size()) begin errors++; $display("FAIL ramp%0d_count: got %0d expected %0d", down, got2.size(), exp2.size()); end
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
            checks++; if (got2[i] != exp2[i]) begin errors++; $display("FAIL ramp%0d_data[%0d]: got %0d expected %0d", down, i, got2[i], exp2[i]); end
            checks++; if (got2_cyc[i] != exp2_cyc[i]) begin errors++; $display("FAIL ramp%0d_latency[%0d]: got cycle %0d expected %0d", down, i, got2_cyc[i], exp2_cyc[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ramp%0d_overflow: got %b expected 0", down, overflow); end
    endtask

    task automatic test_hold();
        clear_q();
        set_ramp(1'b0);
        out_ready = 1'b0;
        stream_frame(1'b0);
        repeat (4) idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== DW'(exp2[0])) begin errors++; $display("FAIL hold_head: got %0d expected %0d", out_data, exp2[0]); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hold_overflow: got %b expected 0", overflow); end
        out_ready = 1'b1;
        repeat (6) idle();
        checks++; if (got2.size() != exp2.size()) begin errors++; $display("FAIL hold_count: got %0d expected %0d", got2.size(), exp2.size()); end
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
            checks++; if (got2[i] != exp2[i]) begin errors++; $display("FAIL hold_data[%0d]: got %0d expected %0d", i, got2[i], exp2[i]); end
            checks++; if (got2_cyc[i] != got2_cyc[0] + i) begin errors++; $display("FAIL hold_drain_cycle[%0d]: got %0d expected %0d", i, got2_cyc[i], got2_cyc[0] + i); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        int first[$];
        do_reset();
        set_ramp(1'b0);
        out_ready = 1'b0;
        stream_frame(1'b0);
        repeat (3) idle();
        first = exp2;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
        stream_frame(1'b0);
        repeat (3) idle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after: got %b expected 1", overflow); end
`ifdef MAX_POOL_FRAME_DONE_EN
        checks++; if (fd_cnt2 != 2) begin errors++; $display("FAIL ovf_frame_done_count: got %0d expected 2", fd_cnt2); end
`endif
        out_ready = 1'b1;
        repeat (8) idle();
        checks++; if (got2.size() != first.size()) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", got2.size(), first.size()); end
        for (int i = 0; i < first.size() && i < got2.size(); i++) begin
            checks++; if (got2[i] != first[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %0d expected %0d", i, got2[i], first[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_cleared: got %b expected 0", overflow); end
        set_random();
        out_ready = 1'b0;
        for (int p = (K - 1) * RS + (K - 1); p <= (K - 1) * RS + (K - 1) + 4; p++) present(p);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered: got %b expected 1", out_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_reset_valid1: got %b expected 0", out_valid1); end
        @(posedge clk); #1;
        rst = 1'b1;
        dut_pos = (K - 1) * RS + (K - 1);
        clear_q();
        set_random();
        out_ready = 1'b1;
        stream_frame(1'b1);
        repeat (6) idle();
        checks++; if (got2.size() != exp2.size()) begin errors++; $display("FAIL mid_count: got %0d expected %0d", got2.size(), exp2.size()); end
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
            checks++; if (got2[i] != exp2[i]) begin errors++; $display("FAIL mid_data[%0d]: got %0d expected %0d", i, got2[i], exp2[i]); end
        end
    endtask

    task automatic test_random_stream();
        clear_q();
        ready_rand = 1'b1;
        for (int f = 0; f < 3; f++) begin
            set_random();
            stream_frame(1'b1);
        end
        ready_rand = 1'b0;
        out_ready = 1'b1;
        repeat (8) idle();
        checks++; if (got2.size() != exp2.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got2.size(), exp2.size()); end
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
            checks++; if (got2[i] != exp2[i]) begin errors++; $display("FAIL rand_data[%0d]: got %0d expected %0d", i, got2[i], exp2[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_stride1();
        do_reset();
        set_ramp(1'b0);
        out_ready = 1'b1;
        stream_frame(1'b0);
        repeat (6) idle();
        checks++; if (got1.size() != exp1.size()) begin errors++; $display("FAIL s1_count: got %0d expected %0d", got1.size(), exp1.size()); end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            checks++; if (got1[i] != exp1[i]) begin errors++; $display("FAIL s1_data[%0d]: got %0d expected %0d", i, got1[i], exp1[i]); end
        end
`ifdef MAX_POOL_FRAME_DONE_EN
        checks++; if (fd_cnt1 != 1) begin errors++; $display("FAIL s1_frame_done_count: got %0d expected 1", fd_cnt1); end
        checks++; if (fd_data1 != exp1[exp1.size() - 1] || fd_valid1 !== 1'b1) begin
            errors++; $display("FAIL s1_frame_done_data: got %0d valid %b expected %0d valid 1", fd_data1, fd_valid1, exp1[exp1.size() - 1]);
        end
        checks++; if (fd_cnt2 != 1) begin errors++; $display("FAIL s2_frame_done_count: got %0d expected 1", fd_cnt2); end
`endif
    endtask

    // FIFO full while a push and a pop land on the same edge: both must happen.
    task automatic test_full_push_pop();
        do_reset();
        set_ramp(1'b0);
        out_ready = 1'b0;
        ready_at_pos = 3 * RS + 4;
        stream_frame(1'b0);
        ready_at_pos = -1;
        repeat (6) idle();
        checks++; if (got1.size() != exp1.size()) begin errors++; $display("FAIL fpp_count: got %0d expected %0d", got1.size(), exp1.size()); end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            checks++; if (got1[i] != exp1[i]) begin errors++; $display("FAIL fpp_data[%0d]: got %0d expected %0d", i, got1[i], exp1[i]); end
        end
        checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", overflow1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b expected 0", out_valid1); end
    endtask

    initial begin
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) window[i][j] = '0;
        test_reset();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_hold();
        test_overflow();
        test_reset_mid();
        test_random_stream();
        test_stride1();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
